// File: rtl/leaderboard_pkg.sv
// Shared widths, BCD digit type, readout state encoding and entry-selection
// helper for the leaderboard reader.
package leaderboard_pkg;

  localparam int RANK_COUNT = 3;
  localparam int SCORE_W    = 8;
  localparam int ID_W       = 3;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } reader_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } sel_t;

  // Lowest-numbered entry at or after 'from' whose mask bit is set.
  function automatic sel_t next_entry(input logic [RANK_COUNT-1:0] mask,
                                      input logic [1:0]            from);
    sel_t s;
    s = '0;
    for (int i = RANK_COUNT - 1; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= from)) begin
        s.found = 1'b1;
        s.idx   = 2'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/leaderboard_reader_if.sv
// Leaderboard input / readout bus: the reader is the slave, the requester and
// beat consumer is the master.
interface leaderboard_reader_if;
  import leaderboard_pkg::*;

  logic               start;
  logic [SCORE_W-1:0] score1, score2, score3;
  logic [ID_W-1:0]    id1, id2, id3;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_rank;
  logic [ID_W-1:0]    out_id;
  bcd_t               out_hund, out_tens, out_ones;
  logic               out_last;
  logic               done;

  modport slave (
    input  start, score1, score2, score3, id1, id2, id3, out_ready,
    output busy, out_valid, out_rank, out_id, out_hund, out_tens, out_ones,
           out_last, done
  );

  modport master (
    output start, score1, score2, score3, id1, id2, id3, out_ready,
    input  busy, out_valid, out_rank, out_id, out_hund, out_tens, out_ones,
           out_last, done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: load captures the binary value and clears
// the digits; each step does one add-3 / shift-left iteration.
module bin2bcd_seq
  import leaderboard_pkg::*;
(
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load,
  input  logic               step,
  input  logic [SCORE_W-1:0] bin,
  output bcd_t               hund,
  output bcd_t               tens,
  output bcd_t               ones
);

  logic [SCORE_W-1:0] shreg;
  bcd_t               hund_adj, tens_adj, ones_adj;

  function automatic bcd_t adj3(input bcd_t d);
    return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
  endfunction

  always_comb begin
    hund_adj = adj3(hund);
    tens_adj = adj3(tens);
    ones_adj = adj3(ones);
  end

  // Hundreds never exceeds 2 for an 8-bit input, so its top bit is dropped.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      shreg <= '0;
      hund  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else if (load) begin
      shreg <= bin;
      hund  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else if (step) begin
      {hund, tens, ones, shreg} <= {hund_adj[2:0], tens_adj, ones_adj, shreg, 1'b0};
    end
  end

endmodule

// File: rtl/leaderboard_reader.sv
// Leaderboard readout: snapshots three ranked scores, converts each to BCD and
// streams them as valid/ready beats. Optional LEADERBOARD_READER_SKIP_ZERO_EN skips zero scores.
module leaderboard_reader
  import leaderboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr_n,
  leaderboard_reader_if.slave  bus
);

  reader_state_t      state, state_nxt;
  logic [SCORE_W-1:0] score_in   [RANK_COUNT];
  logic [SCORE_W-1:0] score_snap [RANK_COUNT];
  logic [ID_W-1:0]    id_snap    [RANK_COUNT];
  logic [1:0]         idx, load_idx;
  logic [2:0]         cnt;
  logic [RANK_COUNT-1:0] mask_in, mask_snap;
  sel_t               first_sel, next_sel;
  logic               accept, conv_load, conv_step, is_last;
  logic [SCORE_W-1:0] load_score;
  bcd_t               hund, tens, ones;

  assign score_in[0] = bus.score1;
  assign score_in[1] = bus.score2;
  assign score_in[2] = bus.score3;

  always_comb begin
    for (int i = 0; i < RANK_COUNT; i++) begin
`ifdef LEADERBOARD_READER_SKIP_ZERO_EN
      mask_in[i]   = |score_in[i];
      mask_snap[i] = |score_snap[i];
`else
      mask_in[i]   = 1'b1;
      mask_snap[i] = 1'b1;
`endif
    end
  end

  assign first_sel = next_entry(mask_in, 2'd0);
  assign next_sel  = next_entry(mask_snap, 2'(idx + 2'd1));
  assign is_last   = !next_sel.found;
  assign accept    = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    conv_load     = 1'b0;
    conv_step     = 1'b0;
    load_idx      = idx;
    bus.busy      = (state != IDLE);
    bus.done      = (state == FINISH);
    bus.out_valid = (state == PRESENT);
    bus.out_rank  = '0;
    bus.out_id    = '0;
    bus.out_hund  = '0;
    bus.out_tens  = '0;
    bus.out_ones  = '0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (first_sel.found) begin
            state_nxt = CONV;
            conv_load = 1'b1;
            load_idx  = first_sel.idx;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      CONV: begin
        conv_step = 1'b1;
        if (cnt == 3'd7) state_nxt = PRESENT;
      end
      PRESENT: begin
        bus.out_rank = 2'(idx + 2'd1);
        bus.out_id   = id_snap[idx];
        bus.out_hund = hund;
        bus.out_tens = tens;
        bus.out_ones = ones;
        bus.out_last = is_last;
        if (bus.out_ready) begin
          if (is_last) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = CONV;
            conv_load = 1'b1;
            load_idx  = next_sel.idx;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first entry loads straight from the inputs; the snapshot lands on the same edge.
  assign load_score = (state == IDLE) ? score_in[load_idx] : score_snap[load_idx];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < RANK_COUNT; i++) begin
        score_snap[i] <= '0;
        id_snap[i]    <= '0;
      end
      idx <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        score_snap[0] <= bus.score1;
        score_snap[1] <= bus.score2;
        score_snap[2] <= bus.score3;
        id_snap[0]    <= bus.id1;
        id_snap[1]    <= bus.id2;
        id_snap[2]    <= bus.id3;
      end
      if (conv_load) begin
        idx <= load_idx;
        cnt <= '0;
      end else if (conv_step) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (conv_load),
    .step  (conv_step),
    .bin   (load_score),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones)
  );

endmodule
